alu_issue_unit: RTL

Execute-stage front end that feeds the registered 8-operation 64-bit ALU and collects its results. Accepts decoded operations over a valid/ready handshake and drives the ALU operand, shift-amount and select lines from registers. Tracks each operation through the ALU's one-cycle registered latency and buffers results in an in-order FIFO. Results are presented to writeback with their tags under a second valid/ready handshake, so downstream stalls never drop an ALU result.

---
 rtl/alu_issue_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_issue_unit.sv
// Execute-stage front end for a registered 64-bit ALU: registers operands onto the ALU,
// tracks its one-cycle latency and buffers tagged results in an in-order, credit-guarded FIFO.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [63:0]     in_a,
  input  logic [63:0]     in_b,
  input  logic [5:0]      in_shamt,
  input  logic [TAGW-1:0] in_tag,
  output logic [63:0]     alu_a,
  output logic [63:0]     alu_b,
  output logic [5:0]      alu_shiftamt,
  output logic [2:0]      alu_sel,
  input  logic [63:0]     alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_result,
  output logic [TAGW-1:0] out_tag
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 2;

  logic [63:0]     alu_a_q, alu_b_q;
  logic [5:0]      alu_sh_q;
  logic [2:0]      alu_sel_q;
  logic            s1_v_q, s2_v_q;
  logic [TAGW-1:0] s1_tag_q, s2_tag_q;
  logic [63:0]     res_q [DEPTH];
  logic [TAGW-1:0] tag_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic          pop_s, push_s, accept_s;
  logic [CW-1:0] in_flight_s, limit_s;

  assign out_valid    = (count_q != '0);
  assign out_result   = res_q[rd_ptr_q];
  assign out_tag      = tag_q[rd_ptr_q];
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_shiftamt = alu_sh_q;
  assign alu_sel      = alu_sel_q;

  // Credit: everything already buffered or still inside the ALU must fit, counting this cycle's pop.
  assign pop_s       = out_valid && out_ready && !flush;
  assign push_s      = s2_v_q && !flush;
  assign in_flight_s = count_q + CW'(s1_v_q) + CW'(s2_v_q);
  assign limit_s     = CW'(DEPTH) + CW'(pop_s);
  assign in_ready    = !rst && !flush && (in_flight_s < limit_s);
  assign accept_s    = in_valid && in_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d = wr_ptr_q + PW'(push_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q   <= 64'd0;
      alu_b_q   <= 64'd0;
      alu_sh_q  <= 6'd0;
      alu_sel_q <= 3'd0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_tag_q  <= '0;
      s2_tag_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= 64'd0;
        tag_q[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        alu_a_q   <= in_a;
        alu_b_q   <= in_b;
        alu_sh_q  <= in_shamt;
        alu_sel_q <= in_op;
        s1_tag_q  <= in_tag;
      end
      // s2 marks the cycle in which alu_result belongs to the op that was in s1.
      s1_v_q   <= accept_s;
      s2_v_q   <= s1_v_q && !flush;
      s2_tag_q <= s1_tag_q;
      if (push_s) begin
        res_q[wr_ptr_q] <= alu_result;
        tag_q[wr_ptr_q] <= s2_tag_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule
